ipu_pattern_gen: RTL and testbench
==================================

Name: ipu_pattern_gen

Overview:
Synthesizable camera-stream source that drives the IPU pixel input interface: iDVAL, iRed/iGreen/iBlue, iX_Cont and iY_Cont. Emits raster frames with a dark background and one bright rectangle at a programmable position and size. Used for on-board self-test and closed-loop checking of the IPU centroid output, in place of the camera front end. Frame timing includes horizontal and vertical blanking, so the IPU sees realistic DVAL gaps.

Parameters:
H_ACTIVE, 640, valid pixels per line
V_ACTIVE, 480, active lines per frame
H_BLANK, 160, cycles with oDVAL low after each active line (>=1)
V_BLANK, 1000, cycles with oDVAL low after the last line's H_BLANK (>=1)
COLOR_W, 12, colour channel width

Ports:
iCLK  in  1  clock
iRST  in  1  reset, asynchronous, active-high
iStart  in  1  single-cycle pulse; starts a frame when idle
iContinuous  in  1  1 = start the next frame automatically after V_BLANK
iBox_X  in  11  box left column
iBox_Y  in  11  box top row
iBox_W  in  11  box width in pixels (0 = no box)
iBox_H  in  11  box height in lines (0 = no box)
oDVAL  out  1  pixel valid
oRed  out  COLOR_W  red channel
oGreen  out  COLOR_W  green channel
oBlue  out  COLOR_W  blue channel
oX_Cont  out  11  column of the current pixel
oY_Cont  out  11  row of the current pixel
oFrame_Start  out  1  pulse coincident with pixel (0,0)
oFrame_Done  out  1  pulse on the last V_BLANK cycle
oBusy  out  1  high whenever the state is not IDLE

Behaviour:
- All outputs are registered. While iRST is high, every output is 0 and the state is IDLE; this holds asynchronously and mid-frame. The frame restarts only on a new iStart after reset is released.
- States: IDLE, ACTIVE, HBLANK, VBLANK.
- IDLE -> ACTIVE on the edge that samples iStart=1.
  - On the same edge: latch iBox_*; drive pixel (0,0) with oDVAL=1 and oFrame_Start=1.
  - Latency from the iStart sample to the first valid pixel is 1 cycle.
- iStart is ignored outside IDLE.
- Box inputs are sampled only at frame start. Changes during a frame have no effect until the next frame.
- ACTIVE:
  - One pixel per cycle; oDVAL=1; oX_Cont goes 0..H_ACTIVE-1 and oY_Cont is constant.
  - After X=H_ACTIVE-1, go to HBLANK.
- HBLANK:
  - H_BLANK cycles with oDVAL=0, colours 0, oX_Cont=0, oY_Cont held.
  - Then, if Y<V_ACTIVE-1: increment Y and go to ACTIVE.
  - Otherwise go to VBLANK with oY_Cont=0.
- VBLANK:
  - V_BLANK cycles with oDVAL=0.
  - oFrame_Done=1 on the final cycle.
  - Next state is ACTIVE (new frame, re-latch box, oFrame_Start) if iContinuous=1 on that cycle, else IDLE.
- Pixel colour when oDVAL=1:
  - Inside box (X>=bx, X<bx+bw, Y>=by, Y<by+bh): oRed=all ones, oGreen=oBlue=0.
  - Outside box: all channels 0.
  - bx+bw and by+bh are computed 12 bits wide; no overflow.
  - A box extending past the frame edge is clipped naturally.
  - A box starting at or beyond H_ACTIVE/V_ACTIVE produces no bright pixels.
- Colour outputs are 0 whenever oDVAL=0.
- Frame length is exactly V_ACTIVE*(H_ACTIVE+H_BLANK)+V_BLANK cycles. Back-to-back continuous frames have no extra gap cycle.

Test Plan:
Use H_ACTIVE=8, V_ACTIVE=4, H_BLANK=2, V_BLANK=5 unless stated.
1. Reset then iStart with box (2,1,3,2) -> oFrame_Start at the cycle after start; bright pixels only at X=2..4, Y=1..2 (6 pixels); oDVAL high for 32 of 45 cycles; oFrame_Done on cycle 45; oBusy falls; returns to IDLE.
2. Box (6,3,5,5) -> bright pixels only at X=6..7, Y=3 (2 pixels), showing clipping. Box (8,0,2,2) or W=0 -> no bright pixel.
3. iContinuous=1, with box changed mid-frame -> the second oFrame_Start comes exactly 45 cycles after the first; the new box appears only in frame 2.
4. iStart pulsed mid-frame -> ignored; frame timing is unchanged.
5. iRST asserted at line 2, pixel 5 -> all outputs 0 immediately. After release, no activity until iStart; then a complete frame from (0,0).
6. Defaults with box (200,0,100,400) -> 400 rows of 100 red pixels; the IPU fed by this block reports centroid X=249, Y=199 (floor).

Source files
------------

// File: rtl/ipu_pattern_gen_if.sv
// Pixel bus between the pattern generator and the IPU input, plus frame controls.
// Latency: n/a (signal bundle only).
// Backpressure: none; the pixel stream is free-running once a frame starts.
interface ipu_pattern_gen_if #(
  parameter int COLOR_W = 12
);
  // Frame control and box geometry, driven by the controller
  logic               iStart;
  logic               iContinuous;
  logic [10:0]        iBox_X;
  logic [10:0]        iBox_Y;
  logic [10:0]        iBox_W;
  logic [10:0]        iBox_H;

  // Pixel stream and frame status, driven by the generator
  logic               oDVAL;
  logic [COLOR_W-1:0] oRed;
  logic [COLOR_W-1:0] oGreen;
  logic [COLOR_W-1:0] oBlue;
  logic [10:0]        oX_Cont;
  logic [10:0]        oY_Cont;
  logic               oFrame_Start;
  logic               oFrame_Done;
  logic               oBusy;

  modport master (
    input  iStart, iContinuous, iBox_X, iBox_Y, iBox_W, iBox_H,
    output oDVAL, oRed, oGreen, oBlue, oX_Cont, oY_Cont,
           oFrame_Start, oFrame_Done, oBusy
  );

  modport slave (
    output iStart, iContinuous, iBox_X, iBox_Y, iBox_W, iBox_H,
    input  oDVAL, oRed, oGreen, oBlue, oX_Cont, oY_Cont,
           oFrame_Start, oFrame_Done, oBusy
  );
endinterface

// File: rtl/ipu_pattern_gen.sv
// Raster test-pattern source: dark frame with one red box, with H/V blanking.
// Latency: first pixel (0,0) appears 1 cycle after iStart is sampled in IDLE.
// Backpressure: none; pixels are emitted one per cycle, consumer must keep up.
module ipu_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 160,
  parameter int V_BLANK  = 1000,
  parameter int COLOR_W  = 12
) (
  input  logic          iCLK,
  input  logic          iRST,
  ipu_pattern_gen_if.master pix
);

  localparam int CNT_MAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

  state_t           state, state_nxt;
  logic [10:0]      x, x_nxt;
  logic [10:0]      y, y_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [10:0]      bx, by, bw, bh;
  logic [10:0]      bx_nxt, by_nxt, bw_nxt, bh_nxt;
  logic             new_frame;
  logic             dval_nxt, red_nxt, start_nxt, done_nxt;
  logic [10:0]      xo_nxt, yo_nxt;

  // Box test with 12-bit end coordinates so x+w never wraps; w or h of 0 never matches.
  function automatic logic in_box(input logic [10:0] px, input logic [10:0] py,
                                  input logic [10:0] x0, input logic [10:0] y0,
                                  input logic [10:0] w,  input logic [10:0] h);
    logic [11:0] xe;
    logic [11:0] ye;
    xe = {1'b0, x0} + {1'b0, w};
    ye = {1'b0, y0} + {1'b0, h};
    return (px >= x0) && ({1'b0, px} < xe) && (py >= y0) && ({1'b0, py} < ye);
  endfunction

  // Next state, raster counters, box latch, and the next registered output values.
  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    cnt_nxt   = cnt;
    bx_nxt    = bx;
    by_nxt    = by;
    bw_nxt    = bw;
    bh_nxt    = bh;
    new_frame = 1'b0;

    case (state)
      IDLE: begin
        if (pix.iStart) new_frame = 1'b1;
      end
      ACTIVE: begin
        if (x == 11'(H_ACTIVE - 1)) begin
          state_nxt = HBLANK;
          x_nxt     = '0;
          cnt_nxt   = '0;
        end else begin
          x_nxt = x + 11'd1;
        end
      end
      HBLANK: begin
        if (cnt == CNT_W'(H_BLANK - 1)) begin
          if (y < 11'(V_ACTIVE - 1)) begin
            state_nxt = ACTIVE;
            y_nxt     = y + 11'd1;
            x_nxt     = '0;
          end else begin
            state_nxt = VBLANK;
            y_nxt     = '0;
            cnt_nxt   = '0;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      VBLANK: begin
        if (cnt == CNT_W'(V_BLANK - 1)) begin
          if (pix.iContinuous) new_frame = 1'b1;
          else                 state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A new frame starts straight at pixel (0,0) with freshly latched box geometry.
    if (new_frame) begin
      state_nxt = ACTIVE;
      x_nxt     = '0;
      y_nxt     = '0;
      bx_nxt    = pix.iBox_X;
      by_nxt    = pix.iBox_Y;
      bw_nxt    = pix.iBox_W;
      bh_nxt    = pix.iBox_H;
    end

    dval_nxt  = (state_nxt == ACTIVE);
    xo_nxt    = dval_nxt ? x_nxt : 11'd0;
    yo_nxt    = (state_nxt == ACTIVE || state_nxt == HBLANK) ? y_nxt : 11'd0;
    red_nxt   = dval_nxt && in_box(x_nxt, y_nxt, bx_nxt, by_nxt, bw_nxt, bh_nxt);
    start_nxt = new_frame;
    done_nxt  = (state_nxt == VBLANK) && (cnt_nxt == CNT_W'(V_BLANK - 1));
  end

  // State, counters, box latch and all outputs are registered; reset clears everything at once.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state            <= IDLE;
      x                <= '0;
      y                <= '0;
      cnt              <= '0;
      bx               <= '0;
      by               <= '0;
      bw               <= '0;
      bh               <= '0;
      pix.oDVAL        <= 1'b0;
      pix.oRed         <= '0;
      pix.oGreen       <= '0;
      pix.oBlue        <= '0;
      pix.oX_Cont      <= '0;
      pix.oY_Cont      <= '0;
      pix.oFrame_Start <= 1'b0;
      pix.oFrame_Done  <= 1'b0;
      pix.oBusy        <= 1'b0;
    end else begin
      state            <= state_nxt;
      x                <= x_nxt;
      y                <= y_nxt;
      cnt              <= cnt_nxt;
      bx               <= bx_nxt;
      by               <= by_nxt;
      bw               <= bw_nxt;
      bh               <= bh_nxt;
      pix.oDVAL        <= dval_nxt;
      pix.oRed         <= {COLOR_W{red_nxt}};
      pix.oGreen       <= '0;
      pix.oBlue        <= '0;
      pix.oX_Cont      <= xo_nxt;
      pix.oY_Cont      <= yo_nxt;
      pix.oFrame_Start <= start_nxt;
      pix.oFrame_Done  <= done_nxt;
      pix.oBusy        <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_ipu_pattern_gen.sv
// Scoreboard bench for ipu_pattern_gen with a small 8x4 raster.
// Expected pixels are queued when a frame is requested and popped as oDVAL pixels arrive.
// Frame timing is checked from recorded oFrame_Start/oFrame_Done cycle stamps.
module tb_ipu_pattern_gen;
  localparam int HA = 8;
  localparam int VA = 4;
  localparam int HB = 2;
  localparam int VB = 5;
  localparam int CW = 12;
  localparam int FRAME = VA * (HA + HB) + VB;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        red;
  } pix_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ipu_pattern_gen_if #(.COLOR_W(CW)) pif ();

  ipu_pattern_gen #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK(VB), .COLOR_W(CW)
  ) dut (
    .iCLK (clk),
    .iRST (rst),
    .pix  (pif.master)
  );

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   start_cyc = 0;
  int   bright = 0;
  int   dval_n = 0;
  pix_t sb[$];
  int   fs_cyc[$];
  int   fd_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard for every valid pixel, checks blanking, stamps pulses.
  always @(negedge clk) begin
    pix_t e;
    if (!rst) begin
      if (pif.oDVAL) begin
        dval_n++;
        if (pif.oRed != 0) bright++;
        chk("busy_in_frame", 32'(pif.oBusy), 32'd1);
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("pix_x",   32'(pif.oX_Cont), 32'(e.x));
          chk("pix_y",   32'(pif.oY_Cont), 32'(e.y));
          chk("pix_red", 32'(pif.oRed),    32'({CW{e.red}}));
          chk("pix_gb",  32'(pif.oGreen | pif.oBlue), 32'd0);
        end
      end else begin
        chk("blank_rgb", 32'((|pif.oRed) | (|pif.oGreen) | (|pif.oBlue)), 32'd0);
      end
      if (pif.oFrame_Start) begin
        fs_cyc.push_back(cyc);
        chk("fs_origin", 32'({pif.oDVAL, pif.oX_Cont, pif.oY_Cont}), 32'({1'b1, 22'd0}));
      end
      if (pif.oFrame_Done) fd_cyc.push_back(cyc);
    end
  end

  task automatic set_box(input int bx, input int by, input int bw, input int bh);
    pif.iBox_X = 11'(bx);
    pif.iBox_Y = 11'(by);
    pif.iBox_W = 11'(bw);
    pif.iBox_H = 11'(bh);
  endtask

  task automatic push_frame(input int bx, input int by, input int bw, input int bh);
    pix_t p;
    for (int yy = 0; yy < VA; yy++) begin
      for (int xx = 0; xx < HA; xx++) begin
        p.x   = 11'(xx);
        p.y   = 11'(yy);
        p.red = (xx >= bx) && (xx < bx + bw) && (yy >= by) && (yy < by + bh);
        sb.push_back(p);
      end
    end
  endtask

  task automatic clear_stats();
    fs_cyc.delete();
    fd_cyc.delete();
    bright = 0;
    dval_n = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 pif.iStart = 1'b1;
    @(posedge clk);
    #1 pif.iStart = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int n_done, input int budget);
    int i = 0;
    while (fd_cyc.size() < n_done && i < budget) begin
      @(posedge clk);
      i++;
    end
    if (fd_cyc.size() < n_done) chk("done_timeout", 32'(fd_cyc.size()), 32'(n_done));
  endtask

  // One isolated frame with timing, pixel-count and end-state checks.
  task automatic run_single(input int bx, input int by, input int bw, input int bh,
                            input int exp_bright);
    clear_stats();
    set_box(bx, by, bw, bh);
    push_frame(bx, by, bw, bh);
    pulse_start();
    wait_done(1, 3 * FRAME);
    repeat (2) @(negedge clk);
    chk("fs_count",    32'(fs_cyc.size()), 32'd1);
    chk("fs_latency",  32'(fs_cyc[0] - start_cyc), 32'd0);
    chk("frame_len",   32'(fd_cyc[0] - fs_cyc[0]), 32'(FRAME - 1));
    chk("dval_cycles", 32'(dval_n), 32'(HA * VA));
    chk("bright",      32'(bright), 32'(exp_bright));
    chk("busy_after",  32'(pif.oBusy), 32'd0);
    chk("sb_empty",    32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst             = 1'b1;
    pif.iStart      = 1'b0;
    pif.iContinuous = 1'b0;
    set_box(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dval",  32'(pif.oDVAL), 32'd0);
    chk("rst_busy",  32'(pif.oBusy), 32'd0);
    chk("rst_xy",    32'({pif.oX_Cont, pif.oY_Cont}), 32'd0);
    chk("rst_pulse", 32'({pif.oFrame_Start, pif.oFrame_Done}), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Basic box, clipped box, off-frame box and zero-width box
    run_single(2, 1, 3, 2, 6);
    run_single(6, 3, 5, 5, 2);
    run_single(8, 0, 2, 2, 0);
    run_single(1, 1, 0, 3, 0);

    // Continuous mode with a box change mid-frame: new box shows only in frame 2
    clear_stats();
    pif.iContinuous = 1'b1;
    set_box(0, 0, 2, 1);
    push_frame(0, 0, 2, 1);
    pulse_start();
    repeat (10) @(posedge clk);
    #1 set_box(5, 2, 3, 2);
    push_frame(5, 2, 3, 2);
    wait_done(1, 3 * FRAME);
    #1 pif.iContinuous = 1'b0;
    wait_done(2, 3 * FRAME);
    repeat (2) @(negedge clk);
    chk("cont_fs_count", 32'(fs_cyc.size()), 32'd2);
    chk("cont_period",   32'(fs_cyc[1] - fs_cyc[0]), 32'(FRAME));
    chk("cont_bright",   32'(bright), 32'd8);
    chk("cont_dval",     32'(dval_n), 32'(2 * HA * VA));
    chk("cont_sb_empty", 32'(sb.size()), 32'd0);
    chk("cont_busy",     32'(pif.oBusy), 32'd0);

    // iStart pulsed mid-frame must be ignored
    clear_stats();
    set_box(1, 0, 2, 4);
    push_frame(1, 0, 2, 4);
    pulse_start();
    repeat (7) @(posedge clk);
    #1 set_box(0, 0, 8, 4);
    pif.iStart = 1'b1;
    @(posedge clk);
    #1 pif.iStart = 1'b0;
    wait_done(1, 3 * FRAME);
    repeat (3) @(negedge clk);
    chk("ign_fs_count", 32'(fs_cyc.size()), 32'd1);
    chk("ign_len",      32'(fd_cyc[0] - fs_cyc[0]), 32'(FRAME - 1));
    chk("ign_bright",   32'(bright), 32'd8);
    chk("ign_sb_empty", 32'(sb.size()), 32'd0);
    chk("ign_busy",     32'(pif.oBusy), 32'd0);

    // Asynchronous reset at line 2, pixel 5
    clear_stats();
    set_box(2, 1, 3, 2);
    push_frame(2, 1, 3, 2);
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 3 * FRAME && !found; i++) begin
      @(negedge clk);
      if (pif.oDVAL && pif.oY_Cont == 11'd2 && pif.oX_Cont == 11'd5) found = 1'b1;
    end
    chk("reach_mid", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_dval",  32'(pif.oDVAL), 32'd0);
    chk("arst_busy",  32'(pif.oBusy), 32'd0);
    chk("arst_xy",    32'({pif.oX_Cont, pif.oY_Cont}), 32'd0);
    chk("arst_red",   32'(pif.oRed), 32'd0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    clear_stats();
    repeat (30) @(negedge clk);
    chk("idle_dval", 32'(dval_n), 32'd0);
    chk("idle_fs",   32'(fs_cyc.size()), 32'd0);
    chk("idle_busy", 32'(pif.oBusy), 32'd0);
    run_single(2, 1, 3, 2, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
